// File: rtl/display_pkg.sv
// Shared definitions for the SSD1306 SPI controller: panel command codes,
// the power-on init sequence and the state encodings.
package display_pkg;

    // SSD1306 command bytes used by the init sequence.
    localparam logic [7:0] DISPLAYOFF          = 8'hAE;
    localparam logic [7:0] CHARGEPUMP          = 8'h8D;
    localparam logic [7:0] SETCONTRAST         = 8'h81;
    localparam logic [7:0] SETPRECHARGE        = 8'hD9;
    localparam logic [7:0] DISPLAYALLON_RESUME = 8'hA4;
    localparam logic [7:0] NORMALDISPLAY       = 8'hA6;
    localparam logic [7:0] DISPLAYON           = 8'hAF;
    localparam logic [7:0] NOP                 = 8'hE3;

    // Largest init sequence the 5-bit ROM index can address.
    localparam int INIT_ROM_MAX = 32;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        LOAD,
        SHIFT,
        GAP,
        IDLE
    } state_t;

    // Byte transmitter phases.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_phase_t;

    // Default init sequence: display off, charge pump on, contrast, precharge,
    // resume from RAM, normal polarity, display on. Entries past the end are NOP.
    // NOTE: the init ROM is a constant function, so it becomes plain decode
    // logic with no storage that would need a reset.
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return DISPLAYOFF;
            5'd1:    return CHARGEPUMP;
            5'd2:    return 8'h14;
            5'd3:    return SETCONTRAST;
            5'd4:    return 8'h70;
            5'd5:    return SETPRECHARGE;
            5'd6:    return 8'hF1;
            5'd7:    return DISPLAYALLON_RESUME;
            5'd8:    return NORMALDISPLAY;
            5'd9:    return DISPLAYON;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode 0 byte transmitter: owns the half-period divider, the shift
// register and the bit counter, and holds chip select high for a programmable
// number of half-periods after each byte before reporting done.
module spi_byte_tx
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 11,
    parameter int GAP_HALVES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       tx_dc,
    output logic       spi_din,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_dc,
    output logic       shift_done,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

    tx_phase_t        phase;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;     // bits still to be shifted out, next one at [6]
    logic             tick;
    logic             last_gap;

    assign tick       = (phase != TX_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_gap   = (gap_cnt == GAP_W'(GAP_HALVES - 1));
    assign shift_done = (phase == TX_SHIFT) && tick && spi_clk && (bit_cnt == 3'd7);
    assign done       = (phase == TX_GAP) && tick && last_gap;

    // Half-period sequencing: data moves on the falling tick, samples on the rising tick.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the pre-edge
        // values; blocking assignments would make the shift order-dependent.
        if (rst) begin
            phase   <= TX_IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            spi_din <= 1'b0;
            spi_clk <= 1'b0;
            spi_cs  <= 1'b1;
            spi_dc  <= 1'b0;
        end else if (start && phase == TX_IDLE) begin
            phase   <= TX_SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= tx_byte[6:0];
            spi_din <= tx_byte[7];
            spi_dc  <= tx_dc;
            spi_cs  <= 1'b0;
            spi_clk <= 1'b0;
        end else if (phase != TX_IDLE) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                if (phase == TX_SHIFT) begin
                    if (!spi_clk) begin
                        spi_clk <= 1'b1;
                    end else begin
                        spi_clk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            spi_cs  <= 1'b1;
                            phase   <= TX_GAP;
                            gap_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            spi_din <= shreg[6];
                            shreg   <= {shreg[5:0], 1'b0};
                        end
                    end
                end else begin
                    if (last_gap) begin
                        phase <= TX_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_ctrl.sv
// SSD1306 SPI controller: pulses the panel reset, streams the init sequence
// from the package ROM, then forwards upstream command/data bytes.
module ssd1306_spi_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 11,
    parameter int RST_CYCLES = 1000,
    parameter int INIT_LEN   = 10,
    parameter int GAP_HALVES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_dc,
    output logic       init_done,
    output logic       busy,
    output logic       spi_din,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_dc,
    output logic       spi_rst
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int IDX_W = $clog2(INIT_ROM_MAX);

    state_t           state;
    logic [CNT_W-1:0] rst_cnt;
    logic [IDX_W-1:0] rom_idx;
    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_dc;
    logic             tx_shift_done;
    logic             tx_done;

    // Ready depends on state only, so in_valid never loops back into in_ready.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Select the byte source for the transmitter: init ROM or upstream.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        tx_dc    = 1'b0;
        if (state == LOAD) begin
            tx_start = 1'b1;
            tx_byte  = init_rom(rom_idx);
            tx_dc    = 1'b0;
        end else if (state == IDLE && in_valid) begin
            tx_start = 1'b1;
            tx_byte  = in_byte;
            tx_dc    = in_dc;
        end
    end

    // Reset pulse, init sequencing and idle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_LOW;
            rst_cnt   <= '0;
            rom_idx   <= '0;
            spi_rst   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                RST_LOW: begin
                    if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        rst_cnt <= '0;
                        spi_rst <= 1'b1;
                        state   <= RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + CNT_W'(1);
                    end
                end
                RST_WAIT: begin
                    if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        rst_cnt <= '0;
                        rom_idx <= '0;
                        state   <= LOAD;
                    end else begin
                        rst_cnt <= rst_cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (tx_shift_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tx_done) begin
                        if (init_done) begin
                            state <= IDLE;
                        end else if (rom_idx == IDX_W'(INIT_LEN - 1)) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rom_idx <= rom_idx + IDX_W'(1);
                            state   <= LOAD;
                        end
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        state <= SHIFT;
                    end
                end
                default: begin
                    state <= RST_LOW;
                end
            endcase
        end
    end

    spi_byte_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_HALVES (GAP_HALVES)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (tx_start),
        .tx_byte    (tx_byte),
        .tx_dc      (tx_dc),
        .spi_din    (spi_din),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .shift_done (tx_shift_done),
        .done       (tx_done)
    );

endmodule

// File: tb/tb_ssd1306_spi_ctrl.sv
// Scoreboard bench for ssd1306_spi_ctrl: stimulus queues the bytes the panel
// should receive, an SPI monitor decodes the pins and checks them in order.
module tb_ssd1306_spi_ctrl;

    localparam int CLK_DIV    = 2;
    localparam int RST_CYCLES = 4;
    localparam int INIT_LEN   = 10;
    localparam int GAP_HALVES = 1;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_dc;
    logic       init_done;
    logic       busy;
    logic       spi_din;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_dc;
    logic       spi_rst;

    always #5 clk = ~clk;

    ssd1306_spi_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES),
        .INIT_LEN   (INIT_LEN),
        .GAP_HALVES (GAP_HALVES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_dc     (in_dc),
        .init_done (init_done),
        .busy      (busy),
        .spi_din   (spi_din),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_dc    (spi_dc),
        .spi_rst   (spi_rst)
    );

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    // Hand-written init sequence the panel must receive.
    logic [7:0] init_bytes [INIT_LEN] = '{8'hAE, 8'h8D, 8'h14, 8'h81, 8'h70,
                                          8'hD9, 8'hF1, 8'hA4, 8'hA6, 8'hAF};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_min(input string name, input int actual, input int min_val);
        n_checks++;
        if (actual < min_val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", name, actual, min_val);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < INIT_LEN; i++) exp_q.push_back('{data: init_bytes[i], dc: 1'b0});
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] b, input logic dc, output int waited);
        waited = 0;
        exp_q.push_back('{data: b, dc: dc});
        in_byte  = b;
        in_dc    = dc;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept within bound", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("init_done reached", init_done, 1'b1);
    endtask

    task automatic wait_ready(output int low_cycles);
        low_cycles = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && low_cycles < 500) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    // SPI pin monitor: mode 0 timing, byte framing and scoreboard compare.
    int         cyc = 0;
    int         din_cyc = 0;
    int         rise_cyc = 0;
    bit         pend_rise = 1'b0;
    bit         in_frame = 1'b0;
    bit         gap_valid = 1'b0;
    bit         dc_ok = 1'b1;
    int         bits = 0;
    int         low_cnt = 0;
    int         high_cnt = 0;
    logic [7:0] sh = 8'h00;
    logic       dc0 = 1'b0;
    logic       prev_clk = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_din = 1'b0;
    xfer_t      e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (rst === 1'b1) begin
                    if (in_frame && spi_cs === 1'b1) begin
                        check("aborted byte left incomplete", 32'(bits < 8), 1'b1);
                        in_frame = 1'b0;
                    end
                    gap_valid = 1'b0;
                    pend_rise = 1'b0;
                    din_cyc   = cyc;
                end else begin
                    if (spi_din !== prev_din) begin
                        if (pend_rise) begin
                            check_min("din hold after rise", cyc - rise_cyc, CLK_DIV);
                            pend_rise = 1'b0;
                        end
                        din_cyc = cyc;
                    end
                    if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
                        check_min("din setup before rise", cyc - din_cyc, CLK_DIV);
                        pend_rise = 1'b1;
                        rise_cyc  = cyc;
                        if (in_frame) begin
                            sh = {sh[6:0], spi_din};
                            bits++;
                        end
                    end
                    if (prev_cs === 1'b1 && spi_cs === 1'b0) begin
                        if (gap_valid) check_min("cs high between bytes", high_cnt, GAP_HALVES * CLK_DIV);
                        in_frame = 1'b1;
                        bits     = 0;
                        sh       = 8'h00;
                        low_cnt  = 0;
                        dc0      = spi_dc;
                        dc_ok    = 1'b1;
                    end
                    if (spi_cs === 1'b0 && in_frame) begin
                        low_cnt++;
                        if (spi_dc !== dc0) dc_ok = 1'b0;
                    end
                    if (prev_cs === 1'b0 && spi_cs === 1'b1 && in_frame) begin
                        in_frame = 1'b0;
                        check("rising edges per byte", bits, 8);
                        check("cs low cycles", low_cnt, 16 * CLK_DIV);
                        check("dc stable in byte", dc_ok, 1'b1);
                        check("byte was expected", 32'(exp_q.size() != 0), 1'b1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("byte value", sh, e.data);
                            check("byte dc", dc0, e.dc);
                        end
                        gap_valid = 1'b1;
                        high_cnt  = 1;
                    end else if (spi_cs === 1'b1) begin
                        high_cnt++;
                    end
                end
            end
            prev_clk = spi_clk;
            prev_cs  = spi_cs;
            prev_din = spi_din;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        int rises;
        int waited;
        logic pclk;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_dc    = 1'b0;

        // Reset values.
        @(posedge clk);
        @(negedge clk);
        check("reset spi_clk", spi_clk, 1'b0);
        check("reset spi_cs", spi_cs, 1'b1);
        check("reset spi_dc", spi_dc, 1'b0);
        check("reset spi_din", spi_din, 1'b0);
        check("reset spi_rst", spi_rst, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset init_done", init_done, 1'b0);
        check("reset busy", busy, 1'b1);
        mon_en = 1'b1;
        push_init();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset pulse: low 4 cycles, high 4 cycles, then the LOAD cycle before cs falls.
        n = 0;
        @(negedge clk);
        while (spi_rst === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("spi_rst low cycles", n, RST_CYCLES);
        m = 0;
        while (spi_rst === 1'b1 && spi_cs === 1'b1 && m < 100) begin
            m++;
            @(negedge clk);
        end
        check("cycles from spi_rst high to cs fall", m, RST_CYCLES + 1);

        // Init stream.
        wait_init();
        check("init bytes all seen", exp_q.size(), 0);
        check("idle in_ready", in_ready, 1'b1);
        check("idle busy", busy, 1'b0);

        // Single data byte.
        @(posedge clk);
        #1;
        send(8'hA5, 1'b1, waited);
        in_valid = 1'b0;
        check("data byte accept latency", waited, 0);
        wait_ready(n);
        check("in_ready low cycles", n, 16 * CLK_DIV + GAP_HALVES * CLK_DIV);
        check("data byte seen", exp_q.size(), 0);

        // Back-to-back with in_valid held high.
        @(posedge clk);
        #1;
        send(8'h3C, 1'b0, waited);
        send(8'hFF, 1'b1, waited);
        send(8'h00, 1'b1, waited);
        in_valid = 1'b0;
        wait_ready(n);
        check("back-to-back bytes seen", exp_q.size(), 0);

        // Reset in the middle of a byte.
        @(posedge clk);
        #1;
        send(8'h5A, 1'b1, waited);
        in_valid = 1'b0;
        n     = 0;
        rises = 0;
        pclk  = spi_clk;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            if (spi_clk === 1'b1 && pclk === 1'b0) rises++;
            pclk = spi_clk;
            n++;
        end
        check("rises before mid-byte reset", rises, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        check("mid-reset spi_cs", spi_cs, 1'b1);
        check("mid-reset spi_rst", spi_rst, 1'b0);
        check("mid-reset in_ready", in_ready, 1'b0);
        check("mid-reset init_done", init_done, 1'b0);
        push_init();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init();
        check("replayed init bytes all seen", exp_q.size(), 0);

        repeat (10) @(negedge clk);
        check("no stray bytes pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
